// File: rtl/ref_window_feeder.sv
// Reads a BLK x BLK pixel block row-major from a 1-cycle-latency memory and
// emits every TAPS-wide horizontal window of each row as one packed word.
module ref_window_feeder #(
    parameter int PIX_W  = 8,
    parameter int BLK    = 15,
    parameter int TAPS   = 7,
    parameter int ADDR_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    mem_rd_en,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic [PIX_W-1:0]        mem_rdata,
    output logic [TAPS*PIX_W-1:0]   win_data,
    output logic                    win_valid,
    input  logic                    win_ready,
    output logic [3:0]              win_row,
    output logic [3:0]              win_col,
    output logic                    win_last,
    output logic [1:0]              dbg_state
);
    // Handshake: a window transfers on a cycle where win_valid && win_ready; while
    // win_valid is high and win_ready low, win_data/row/col/last hold steady.

    localparam int              FILL_W    = $clog2(TAPS);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BLK * BLK - 1);
    localparam logic [3:0]      EDGE_IDX  = 4'(BLK - 1);
    localparam logic [3:0]      COL_OFS   = 4'(TAPS - 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(TAPS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t                   r_state, w_next;
    logic [ADDR_W-1:0]        r_addr;
    logic                     r_rd_pend;
    logic [1:0][PIX_W-1:0]    r_fifo;
    logic                     r_wp, r_rp;
    logic [1:0]               r_cnt;
    logic [TAPS*PIX_W-1:0]    r_shift;
    logic [FILL_W-1:0]        r_fill;
    logic [3:0]               r_pcol, r_prow;
    logic [TAPS*PIX_W-1:0]    r_win_data;
    logic                     r_win_valid, r_win_last, r_done;
    logic [3:0]               r_win_row, r_win_col;

    logic                     w_rd_en, w_start_walk, w_hs;
    logic                     w_avail, w_pop, w_deq, w_push, w_load;
    logic [PIX_W-1:0]         w_head;
    logic [TAPS*PIX_W-1:0]    w_shift_nx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        w_rd_en      = 1'b0;
        w_start_walk = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next       = S_RUN;
                    w_start_walk = 1'b1;
                end
            end
            S_RUN: begin
                if (({1'b0, r_cnt} + {2'b00, r_rd_pend}) < 3'd2) begin
                    w_rd_en = 1'b1;
                    if (r_addr == LAST_ADDR) w_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (w_hs && r_win_last) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // The returning read word is visible at the FIFO head in its arrival cycle,
    // so an empty FIFO does not cost a cycle and reads can stream back to back.
    assign w_hs       = r_win_valid && win_ready;
    assign w_avail    = (r_cnt != 2'd0) || r_rd_pend;
    assign w_head     = (r_cnt != 2'd0) ? r_fifo[r_rp] : mem_rdata;
    assign w_pop      = w_avail && ((r_fill != FILL_FULL) || !r_win_valid || win_ready);
    assign w_deq      = w_pop && (r_cnt != 2'd0);
    assign w_push     = r_rd_pend && !(w_pop && (r_cnt == 2'd0));
    assign w_load     = w_pop && (r_fill == FILL_FULL);
    assign w_shift_nx = {w_head, r_shift[TAPS*PIX_W-1:PIX_W]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr    <= '0;
            r_rd_pend <= 1'b0;
            r_fifo    <= '0;
            r_wp      <= 1'b0;
            r_rp      <= 1'b0;
            r_cnt     <= 2'd0;
        end else begin
            r_rd_pend <= w_rd_en;
            if (w_start_walk)  r_addr <= '0;
            else if (w_rd_en)  r_addr <= r_addr + 1'b1;
            if (w_push) begin
                r_fifo[r_wp] <= mem_rdata;
                r_wp         <= ~r_wp;
            end
            if (w_deq) r_rp <= ~r_rp;
            case ({w_push, w_deq})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Fill restarts at each row end so a window never straddles two rows.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift <= '0;
            r_fill  <= '0;
            r_pcol  <= '0;
            r_prow  <= '0;
        end else if (w_start_walk) begin
            r_fill <= '0;
            r_pcol <= '0;
            r_prow <= '0;
        end else if (w_pop) begin
            r_shift <= w_shift_nx;
            if (r_pcol == EDGE_IDX) begin
                r_pcol <= '0;
                r_fill <= '0;
                if (r_prow != EDGE_IDX) r_prow <= r_prow + 4'd1;
            end else begin
                r_pcol <= r_pcol + 4'd1;
                if (r_fill != FILL_FULL) r_fill <= r_fill + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_win_data  <= '0;
            r_win_valid <= 1'b0;
            r_win_row   <= '0;
            r_win_col   <= '0;
            r_win_last  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= (r_state == S_FLUSH) && w_hs && r_win_last;
            if (w_load) begin
                r_win_data  <= w_shift_nx;
                r_win_row   <= r_prow;
                r_win_col   <= r_pcol - COL_OFS;
                r_win_last  <= (r_prow == EDGE_IDX) && (r_pcol == EDGE_IDX);
                r_win_valid <= 1'b1;
            end else if (win_ready) begin
                r_win_valid <= 1'b0;
            end
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign mem_rd_en = w_rd_en;
    assign mem_addr  = r_addr;
    assign win_data  = r_win_data;
    assign win_valid = r_win_valid;
    assign win_row   = r_win_row;
    assign win_col   = r_win_col;
    assign win_last  = r_win_last;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_ref_window_feeder.sv
// Bench for ref_window_feeder: memory model, window scoreboard built from the
// block contents, directed window table and multi-cycle corner sequences.
module tb_ref_window_feeder;
    localparam int PIX_W  = 8;
    localparam int BLK    = 15;
    localparam int TAPS   = 7;
    localparam int ADDR_W = 8;
    localparam int WPR    = BLK - TAPS + 1;
    localparam int NWIN   = WPR * BLK;
    localparam int DW     = TAPS * PIX_W;
    localparam int W      = 1 + 4 + 4 + DW;

    logic              clk, reset, start;
    logic              busy, done, mem_rd_en, win_valid, win_ready, win_last;
    logic [ADDR_W-1:0] mem_addr;
    logic [PIX_W-1:0]  mem_rdata;
    logic [DW-1:0]     win_data;
    logic [3:0]        win_row, win_col;
    logic [1:0]        dbg_state;

    ref_window_feeder #(.PIX_W(PIX_W), .BLK(BLK), .TAPS(TAPS), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .win_data(win_data), .win_valid(win_valid), .win_ready(win_ready),
        .win_row(win_row), .win_col(win_col), .win_last(win_last),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // ---------------- memory model ----------------
    logic [PIX_W-1:0] mem [0:255];
    initial mem_rdata = '0;
    always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    int           hs_t[$];
    int           n_win, done_cnt, rd_cnt, ready_mode;
    logic [ADDR_W-1:0] exp_addr;
    bit           mon_en, prev_stall, prev_last_hs;
    logic [W-1:0] held;

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // ---------------- driver: win_ready ----------------
    initial begin
        win_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       win_ready = 1'b1;
                1:       win_ready = 1'($urandom_range(0, 1));
                default: win_ready = 1'b0;
            endcase
        end
    end

    // ---------------- reference model ----------------
    task automatic fill_mem(input int mode);
        for (int a = 0; a < 256; a++) begin
            if (mode == 0) mem[a] = 8'(((a / BLK) * 16 + (a % BLK)) % 256);
            else           mem[a] = 8'($urandom_range(0, 255));
        end
    endtask

    task automatic build_expected();
        logic [DW-1:0] d;
        logic          l;
        exp_q.delete();
        for (int r = 0; r < BLK; r++) begin
            for (int c = 0; c < WPR; c++) begin
                d = '0;
                for (int k = 0; k < TAPS; k++) d[k*PIX_W +: PIX_W] = mem[r*BLK + c + k];
                l = (r == BLK - 1) && (c == WPR - 1);
                exp_q.push_back({l, 4'(r), 4'(c), d});
            end
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [W-1:0] cur;
        if (reset || !mon_en) begin
            prev_stall   = 1'b0;
            prev_last_hs = 1'b0;
        end else begin
            cur = {win_last, win_row, win_col, win_data};
            if (prev_stall) begin
                chk("hold_valid", W'(win_valid), W'(1));
                chk("hold_payload", cur, held);
            end
            if (done) begin
                done_cnt++;
                chk("done_after_last", W'(prev_last_hs), W'(1));
                chk("busy_low_at_done", W'(busy), W'(0));
            end
            if (mem_rd_en) begin
                chk("rd_addr", W'(mem_addr), W'(exp_addr));
                exp_addr++;
                rd_cnt++;
            end
            prev_last_hs = 1'b0;
            if (win_valid && win_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_window got=%0h exp=none", cur);
                end else begin
                    chk("window", cur, exp_q.pop_front());
                end
                got_q.push_back(cur);
                hs_t.push_back(cyc_cnt);
                n_win++;
                prev_last_hs = win_last;
            end
            prev_stall = win_valid && !win_ready;
            held       = cur;
        end
    end

    // ---------------- walk sequences ----------------
    task automatic begin_walk(input int mode, input int rmode, input bit check_lat);
        int lat;
        fill_mem(mode);
        build_expected();
        got_q.delete();
        hs_t.delete();
        n_win = 0; done_cnt = 0; rd_cnt = 0; exp_addr = '0;
        ready_mode = rmode;
        mon_en = 1'b1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("busy_after_start", W'(busy), W'(1));
        if (check_lat) begin
            lat = 0;
            while (!win_valid && lat < 20) begin
                @(posedge clk); #1;
                lat++;
            end
            checks++;
            if (lat > 10) begin
                failures++;
                $display("FAIL first_latency got=%0d exp<=10", lat);
            end
        end
    endtask

    task automatic finish_walk();
        int cyc;
        cyc = 0;
        while (done_cnt == 0 && cyc < 4000) begin
            @(negedge clk);
            cyc++;
        end
        if (done_cnt == 0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout got=%0d exp=1", done_cnt);
        end
        repeat (4) @(negedge clk);
        chk("win_count", W'(n_win), W'(NWIN));
        chk("exp_q_empty", W'(exp_q.size()), W'(0));
        chk("done_once", W'(done_cnt), W'(1));
        chk("rd_count", W'(rd_cnt), W'(BLK * BLK));
        chk("busy_idle", W'(busy), W'(0));
    endtask

    task automatic hold_sequence();
        int cyc;
        cyc = 0;
        while (!win_valid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("hold0_valid", W'(win_valid), W'(1));
            chk("hold0_pos", W'({win_row, win_col}), W'(0));
        end
        checks++;
        if (rd_cnt > TAPS + 2) begin
            failures++;
            $display("FAIL hold0_reads got=%0d exp<=%0d", rd_cnt, TAPS + 2);
        end
        ready_mode = 0;
    endtask

    typedef struct {
        int            row;
        int            col;
        logic [DW-1:0] data;
        logic          last;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int idx;
        int cyc;
        reset = 1'b1; start = 1'b0; mon_en = 1'b0; ready_mode = 0;
        tbl[0] = '{0, 0, 56'h06050403020100, 1'b0};
        tbl[1] = '{0, 1, 56'h07060504030201, 1'b0};
        tbl[2] = '{0, 8, 56'h0E0D0C0B0A0908, 1'b0};
        tbl[3] = '{1, 0, 56'h16151413121110, 1'b0};
        tbl[4] = '{7, 3, 56'h79787776757473, 1'b0};
        tbl[5] = '{14, 8, 56'hEEEDECEBEAE9E8, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", W'({busy, done, mem_rd_en, win_valid, win_last}), W'(0));
        reset = 1'b0;
        @(negedge clk);
        chk("idle_after_rst", W'({busy, done, mem_rd_en, win_valid}), W'(0));
        chk("idle_data", W'(win_data), W'(0));

        // directed pattern, ready always high: table + throughput
        begin_walk(0, 0, 1'b1);
        finish_walk();
        for (int i = 0; i < 6; i++) begin
            idx = tbl[i].row * WPR + tbl[i].col;
            if (idx < got_q.size())
                chk($sformatf("tbl_r%0d_c%0d", tbl[i].row, tbl[i].col), got_q[idx],
                    {tbl[i].last, 4'(tbl[i].row), 4'(tbl[i].col), tbl[i].data});
        end
        if (hs_t.size() > WPR) begin
            for (int c = 1; c < WPR; c++) chk("row0_back_to_back", W'(hs_t[c] - hs_t[c-1]), W'(1));
            chk("row_start_bubble", W'(hs_t[WPR] - hs_t[WPR-1]), W'(TAPS));
        end

        // random data, random ready
        begin_walk(1, 1, 1'b0);
        finish_walk();

        // ready held low after first window
        begin_walk(1, 2, 1'b0);
        hold_sequence();
        finish_walk();

        // start re-pulsed during the walk
        begin_walk(0, 1, 1'b0);
        for (int p = 0; p < 3; p++) begin
            repeat ($urandom_range(5, 30)) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        finish_walk();

        // async reset in the middle of row 7
        begin_walk(1, 0, 1'b0);
        cyc = 0;
        while (n_win < 7 * WPR + 3 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        #2 reset = 1'b1;
        #1;
        chk("arst_ctrl", W'({busy, done, mem_rd_en, win_valid, win_last}), W'(0));
        chk("arst_addr", W'(mem_addr), W'(0));
        chk("arst_data", W'({win_row, win_col, win_data}), W'(0));
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (6) @(negedge clk);
        chk("no_done_after_abort", W'(done_cnt), W'(0));
        chk("idle_after_abort", W'(busy), W'(0));
        begin_walk(0, 0, 1'b0);
        finish_walk();
        if (got_q.size() > 0) chk("restart_first", got_q[0],
            {tbl[0].last, 4'(tbl[0].row), 4'(tbl[0].col), tbl[0].data});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
